// File: rtl/chiplet_input_mux.sv
// chiplet_input_mux: per-port input FIFOs feeding a wormhole-locked output stage; define CHIPLET_INPUT_MUX_OUTREG_EN for a registered output
module chiplet_input_mux #(
    parameter int TILES      = 2,
    parameter int PLANES     = 2,
    parameter int FLIT_WIDTH = 34,
    parameter int DEPTH      = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [TILES*PLANES*FLIT_WIDTH-1:0]     in_data,
    input  logic [TILES*PLANES-1:0]                in_valid,
    output logic [TILES*PLANES-1:0]                in_ready,
    output logic [TILES*PLANES-1:0]                request,
    input  logic [TILES*PLANES-1:0]                grant,
    input  logic                                   grant_valid,
    output logic                                   forwarding_head,
    output logic                                   forwarding_tail,
    output logic [FLIT_WIDTH-1:0]                  out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready
);
    localparam int N  = TILES * PLANES;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, PKT} state_t;

    state_t                state, state_nx;
    logic [LW-1:0]         lock_port, g, sel;
    logic [FLIT_WIDTH-1:0] mem [N][DEPTH];
    logic [AW:0]           wp [N];
    logic [AW:0]           rp [N];
    logic [N-1:0]          empty, full, push, pop_vec;
    logic [FLIT_WIDTH-1:0] flit;
    logic                  adv, pop, is_tail;

    assign in_ready = rst ? '0 : ~full;
    assign push     = in_valid & in_ready;
    assign request  = ~empty;
    assign sel      = (state == IDLE) ? g : lock_port;
    assign flit     = mem[sel][rp[sel][AW-1:0]];
    assign is_tail  = flit[FLIT_WIDTH-2];
    assign pop      = adv && !empty[sel] && ((state == IDLE) ? grant_valid : 1'b1);

    // FIFO occupancy flags and the one-hot pop decode
    always_comb begin
        for (int i = 0; i < N; i++) begin
            empty[i]   = wp[i] == rp[i];
            full[i]    = (wp[i][AW] != rp[i][AW]) && (wp[i][AW-1:0] == rp[i][AW-1:0]);
            pop_vec[i] = pop && (sel == LW'(i));
        end
    end

    // one-hot grant to port index
    always_comb begin
        g = '0;
        for (int i = 0; i < N; i++)
            if (grant[i]) g = LW'(i);
    end

    // FIFO pointers; they wrap naturally with the extra lap bit
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                wp[i] <= '0;
                rp[i] <= '0;
            end else begin
                if (push[i]) wp[i] <= wp[i] + 1'b1;
                if (pop_vec[i]) rp[i] <= rp[i] + 1'b1;
            end
        end
    end

    // FIFO storage, not reset: contents are only visible through the pointers
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (push[i]) mem[i][wp[i][AW-1:0]] <= in_data[i*FLIT_WIDTH +: FLIT_WIDTH];
    end

    // state register and packet lock, captured from the grant on a non-tail head
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lock_port <= '0;
        end else begin
            state <= state_nx;
            if (pop && state == IDLE && !is_tail) lock_port <= g;
        end
    end

    // a pop opens a packet unless the flit is a tail, which always returns to IDLE
    always_comb begin
        state_nx        = state;
        forwarding_head = 1'b0;
        forwarding_tail = 1'b0;
        if (pop) begin
            forwarding_head = state == IDLE;
            forwarding_tail = is_tail;
            state_nx        = is_tail ? IDLE : PKT;
        end
    end

`ifdef CHIPLET_INPUT_MUX_OUTREG_EN
    assign adv = !out_valid || out_ready;

    // output register: load on pop, drain on downstream accept
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= flit;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`else
    assign adv       = out_ready;
    assign out_data  = flit;
    assign out_valid = (state == IDLE) ? grant_valid : !empty[lock_port];
`endif

    // HEAD must be set exactly on the first popped flit of a packet
    assert property (@(posedge clk) disable iff (rst) pop |-> (flit[FLIT_WIDTH-1] == (state == IDLE)))
        else $warning("chiplet_input_mux: HEAD/TAIL protocol violation");
endmodule

// File: doc/chiplet_input_mux.md
# chiplet_input_mux

Input-side flit buffering and multiplexing stage for the chiplet router, paired with the TILES*PLANES-to-1 router arbiter. It buffers flits from TILES*PLANES input ports in per-port FIFOs and drives the arbiter's `request` vector. It consumes `grant`/`grant_valid`, latches the winning port for the length of a wormhole packet, and forwards that packet's flits to one output port. It generates the arbiter's `forwarding_head` and `forwarding_tail` strobes.

## Interface
Parameters:
- `TILES`, default 2: number of tiles.
- `PLANES`, default 2: number of NoC planes. N = TILES*PLANES.
- `FLIT_WIDTH`, default 34: flit width in bits. Bit FLIT_WIDTH-1 is HEAD and bit FLIT_WIDTH-2 is TAIL. A single-flit packet has both set.
- `DEPTH`, default 4: per-port FIFO depth. Must be a power of two and ≥2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_data`  in  N×FLIT_WIDTH  flit per input port.
- `in_valid`  in  N  input flit valid.
- `in_ready`  out  N  input FIFO can accept a flit.
- `request`  out  N  to arbiter; bit i means FIFO i is non-empty.
- `grant`  in  N  from arbiter; one-hot or zero.
- `grant_valid`  in  1  from arbiter.
- `forwarding_head`  out  1  head flit popped this cycle.
- `forwarding_tail`  out  1  tail flit popped this cycle.
- `out_data`  out  FLIT_WIDTH  output flit.
- `out_valid`  out  1  output flit valid.
- `out_ready`  in  1  downstream accepts the flit.

## Operation
- **FIFO i**:
  - Push when `in_valid[i] & in_ready[i]`.
  - `in_ready[i]` = !full_i. It is 0 while `rst` is high.
  - Push and pop in the same cycle are allowed when the FIFO is non-empty. A full FIFO never pushes.
  - Read and write pointers are log2(DEPTH)+1 bits and wrap naturally.
- **`request`** = the non-empty vector, every cycle, in both states.
- **`adv`** = output stage can take a flit (see Configuration).
- **FSM with states IDLE and PKT, plus register `lock_port`** (log2 N bits):
  - IDLE: if `grant_valid & adv`, pop FIFO g, where g = index of `grant`. Assert `forwarding_head`.
    - If the popped flit also has TAIL set, assert `forwarding_tail` and stay in IDLE.
    - Otherwise set `lock_port` <= g and go to PKT.
  - PKT: if FIFO[`lock_port`] is non-empty and `adv`, pop it.
    - If TAIL is set, assert `forwarding_tail` and go to IDLE.
    - `grant`/`grant_valid` are ignored in PKT.
  - An empty locked FIFO mid-packet stalls the block. The lock is held with no timeout.
- **`forwarding_head`/`forwarding_tail`** are combinational and asserted only in a pop cycle. Both are asserted together for single-flit packets.
- **Protocol rule**: a flit popped in IDLE must have HEAD set. A HEAD flit popped in PKT is a protocol error: flag it in simulation and forward it as a body flit.
- **Reset mid-packet**: FIFOs flush, FSM goes to IDLE, output is invalidated. The arbiter shares `rst`.

## Timing
- Reset values: `in_ready`=0 during rst and all-ones the cycle after; `request`=0; `forwarding_head`=0; `forwarding_tail`=0; `out_valid`=0; `out_data`=0 (registered mode); FSM=IDLE; `lock_port`=0.
- A push at edge t makes `request[i]`=1 in cycle t+1.
  - With output register: pop in cycle t+1, `out_valid`=1 in cycle t+2.
  - Without output register: flit presented in cycle t+1.
- Steady-state throughput is 1 flit/cycle per packet, with no bubble between back-to-back packets. The tail cycle unlocks the arbiter, so the next head can pop in the following cycle.
- `out_valid`/`out_data` hold stable while `out_valid & !out_ready`.

## Configuration
- Macro: `CHIPLET_INPUT_MUX_OUTREG_EN`.
- **Defined**: one output register.
  - `adv` = !out_valid | out_ready.
  - A pop loads the register. `out_valid` clears on `out_ready` with no pop.
- **Undefined**: combinational output.
  - `out_data` = head of the selected FIFO.
  - `out_valid` = (IDLE & `grant_valid`) | (PKT & FIFO[`lock_port`] non-empty).
  - `adv` = `out_ready`. Pop happens on the handshake.

## Test plan
(N=4, DEPTH=4, FLIT_WIDTH=34, registered mode unless noted.)
- **Single 3-flit packet on port 2**, `out_ready`=1 → `out_valid` cycles 2–4 carry the flits in order. `forwarding_head` in cycle 1, `forwarding_tail` in cycle 3.
- **3-flit packets on ports 0 and 1 simultaneously** → port 0's packet is output completely, then port 1's with no interleaving. The next head follows port 0's tail after 0 idle cycles.
- **Single-flit packet (HEAD|TAIL)** → `forwarding_head` and `forwarding_tail` are both high in the same cycle and the FSM stays in IDLE.
- **Hold `out_ready`=0 for 5 cycles mid-packet while writing 6 flits to port 3** → `in_ready[3]` drops after 4 buffered flits and `out_data` is held stable. After release, all flits exit in order with none lost or duplicated.
- **Port 1 FIFO empties after its head flit; body arrives 3 cycles later** → lock is held, port 0 requests are not served, and the packet resumes when the body arrives.
- **Assert `rst` mid-packet** → next cycle `out_valid`=0, `request`=0, FSM in IDLE. A fresh packet afterwards is forwarded normally. Repeat in combinational mode to check 1-cycle latency.
